lsu_multicycle: RTL and testbench

- Parametrised multi-cycle load/store unit; successor to the single-cycle core's combinational memory path.
- Takes one load/store request from the execute stage and generates byte enables and write-lane data.
- Drives a req/gnt/rvalid memory port, then returns sign/zero-extended load data or an error.
- Generalised to XLEN 32/64 (adds LD, SD, LWU) and to memories with arbitrary grant/response latency.

---
 rtl/lsu_multicycle.sv | 218 +++++++++++++++++++++
 tb/tb_lsu_multicycle.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_multicycle.sv
// Multi-cycle load/store unit driving a req/gnt/rvalid memory port.
// Optional REQ/WAIT watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_multicycle #(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [3:0]            req_func_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [XLEN-1:0]       req_wdata_i,
  output logic                  resp_valid_o,
  output logic [XLEN-1:0]       resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  resp_misaligned_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [XLEN/8-1:0]     mem_be_o,
  output logic [XLEN-1:0]       mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [XLEN-1:0]       mem_rdata_i,
  input  logic                  mem_err_i
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [NB-1:0]   BE_B = NB'(1);
  localparam logic [NB-1:0]   BE_H = NB'(3);
  localparam logic [NB-1:0]   BE_W = NB'(15);
  localparam logic [XLEN-1:0] M8   = XLEN'(64'hFF);
  localparam logic [XLEN-1:0] M16  = XLEN'(64'hFFFF);
  localparam logic [XLEN-1:0] M32  = XLEN'(64'hFFFF_FFFF);

  // 0 byte, 1 half, 2 word, 3 double
  function automatic logic [1:0] f_size(input logic [3:0] f);
    logic [1:0] s;
    s = 2'd0;
    case (f)
      4'd1, 4'd3, 4'd6:  s = 2'd1;
      4'd0, 4'd5, 4'd10: s = 2'd2;
      4'd8, 4'd9:        s = 2'd3;
      default:           s = 2'd0;
    endcase
    return s;
  endfunction

  function automatic logic f_store(input logic [3:0] f);
    return f inside {4'd5, 4'd6, 4'd7, 4'd9};
  endfunction

  function automatic logic f_uns(input logic [3:0] f);
    return f inside {4'd3, 4'd4, 4'd10};
  endfunction

  logic [1:0]            r_state;
  logic [3:0]            r_func;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [XLEN-1:0]       r_wdata;
  logic [XLEN-1:0]       r_rdata;
  logic                  r_err;
  logic                  r_mis;

  logic            w_illegal;
  logic            w_mis;
  logic            w_req;
  logic            w_resp;
  logic            w_tmo;
  logic [1:0]      w_rsize;
  logic [LW-1:0]   w_lane;
  logic [NB-1:0]   w_be;
  logic [XLEN-1:0] w_sh;
  logic [XLEN-1:0] w_msk;
  logic            w_sgn;
  logic [XLEN-1:0] w_ld;

  always_comb begin
    w_illegal = (req_func_i > 4'd10) ||
                ((XLEN == 32) && (req_func_i >= 4'd8));
    w_mis = 1'b0;
    case (f_size(req_func_i))
      2'd1:    w_mis = req_addr_i[0];
      2'd2:    w_mis = |req_addr_i[1:0];
      2'd3:    w_mis = |req_addr_i[2:0];
      default: w_mis = 1'b0;
    endcase
  end

  assign w_rsize = f_size(r_func);
  assign w_lane  = r_addr[LW-1:0];
  assign w_req   = (r_state == S_REQ);
  assign w_resp  = (r_state == S_RESP);

  always_comb begin
    w_be = '1;
    case (w_rsize)
      2'd0:    w_be = BE_B << w_lane;
      2'd1:    w_be = BE_H << w_lane;
      2'd2:    w_be = BE_W << w_lane;
      default: w_be = '1;
    endcase
  end

  // Load lane shift, then mask to access width and fill upper bits
  always_comb begin
    w_sh  = mem_rdata_i >> {w_lane, 3'b000};
    w_msk = '1;
    w_sgn = 1'b0;
    case (w_rsize)
      2'd0: begin
        w_msk = M8;
        w_sgn = w_sh[7];
      end
      2'd1: begin
        w_msk = M16;
        w_sgn = w_sh[15];
      end
      2'd2: begin
        w_msk = M32;
        w_sgn = w_sh[31];
      end
      default: begin
        w_msk = '1;
        w_sgn = 1'b0;
      end
    endcase
    w_sgn = w_sgn & ~f_uns(r_func);
    w_ld  = (w_sh & w_msk) | ({XLEN{w_sgn}} & ~w_msk);
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (w_req || (r_state == S_WAIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_tmo = (r_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_func  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_func  <= req_func_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_rdata <= '0;
            r_err   <= w_illegal | w_mis;
            r_mis   <= ~w_illegal & w_mis;
            r_state <= (w_illegal | w_mis) ? S_RESP : S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            r_state <= S_WAIT;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            r_err   <= mem_err_i;
            r_rdata <= (mem_err_i | f_store(r_func)) ? '0 : w_ld;
            r_state <= S_RESP;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o       = (r_state == S_IDLE);
  assign resp_valid_o      = w_resp;
  assign resp_rdata_o      = w_resp ? r_rdata : '0;
  assign resp_err_o        = w_resp & r_err;
  assign resp_misaligned_o = w_resp & r_mis;

  assign mem_req_o   = w_req;
  assign mem_we_o    = w_req & f_store(r_func);
  assign mem_addr_o  = w_req ? (r_addr & ~ADDR_WIDTH'(NB - 1)) : '0;
  assign mem_be_o    = w_req ? w_be : '0;
  assign mem_wdata_o = w_req ? (r_wdata << {w_lane, 3'b000}) : '0;

endmodule

// File: tb/tb_lsu_multicycle.sv
// Scoreboard bench for lsu_multicycle: 32- and 64-bit instances.
// Expected responses queued by stimulus, checked by a negedge monitor.
module tb_lsu_multicycle;

  typedef struct {
    logic [63:0] rd;
    logic        err;
    logic        mis;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  logic        clk, rst, v, gnt, rvalid, merr, dsel;
  logic [3:0]  func;
  logic [31:0] addr;
  logic [63:0] wdata, rdata;

  logic        m32_ready, m32_rv, m32_err, m32_mis, m32_req, m32_we;
  logic [31:0] m32_rd, m32_addr, m32_wd;
  logic [3:0]  m32_be;
  logic        m64_ready, m64_rv, m64_err, m64_mis, m64_req, m64_we;
  logic [63:0] m64_rd, m64_wd;
  logic [31:0] m64_addr;
  logic [7:0]  m64_be;

  logic        obs_ready, obs_req, obs_we;
  logic [31:0] obs_addr;
  logic [7:0]  obs_be;
  logic [63:0] obs_wd;

  assign obs_ready = dsel ? m64_ready : m32_ready;
  assign obs_req   = dsel ? m64_req : m32_req;
  assign obs_we    = dsel ? m64_we : m32_we;
  assign obs_addr  = dsel ? m64_addr : m32_addr;
  assign obs_be    = dsel ? m64_be : {4'b0, m32_be};
  assign obs_wd    = dsel ? m64_wd : {32'b0, m32_wd};

  lsu_multicycle #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) u32 (
    .clk(clk), .rst(rst),
    .req_valid_i(v & ~dsel), .req_ready_o(m32_ready),
    .req_func_i(func), .req_addr_i(addr), .req_wdata_i(wdata[31:0]),
    .resp_valid_o(m32_rv), .resp_rdata_o(m32_rd),
    .resp_err_o(m32_err), .resp_misaligned_o(m32_mis),
    .mem_req_o(m32_req), .mem_gnt_i(gnt & ~dsel), .mem_we_o(m32_we),
    .mem_addr_o(m32_addr), .mem_be_o(m32_be), .mem_wdata_o(m32_wd),
    .mem_rvalid_i(rvalid & ~dsel), .mem_rdata_i(rdata[31:0]),
    .mem_err_i(merr)
  );

  lsu_multicycle #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) u64 (
    .clk(clk), .rst(rst),
    .req_valid_i(v & dsel), .req_ready_o(m64_ready),
    .req_func_i(func), .req_addr_i(addr), .req_wdata_i(wdata),
    .resp_valid_o(m64_rv), .resp_rdata_o(m64_rd),
    .resp_err_o(m64_err), .resp_misaligned_o(m64_mis),
    .mem_req_o(m64_req), .mem_gnt_i(gnt & dsel), .mem_we_o(m64_we),
    .mem_addr_o(m64_addr), .mem_be_o(m64_be), .mem_wdata_o(m64_wd),
    .mem_rvalid_i(rvalid & dsel), .mem_rdata_i(rdata),
    .mem_err_i(merr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act,
                              input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void pop_cmp(input string nm, input logic [63:0] rd,
                                  input logic e, input logic m);
    exp_t x;
    if (sbq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s.unexpected: got resp rdata=%h err=%b, expected none",
               nm, rd, e);
      return;
    end
    x = sbq.pop_front();
    chk({nm, ".rdata"}, rd, x.rd);
    chk({nm, ".err"}, 64'(e), 64'(x.err));
    chk({nm, ".mis"}, 64'(m), 64'(x.mis));
    chk({nm, ".cycle"}, 64'(cyc), 64'(x.cyc));
  endfunction

  initial forever begin
    @(negedge clk);
    if (m32_rv) pop_cmp("r32", {32'b0, m32_rd}, m32_err, m32_mis);
    else chk("idle32", 64'({m32_rd, m32_err, m32_mis}), 64'd0);
    if (m64_rv) pop_cmp("r64", m64_rd, m64_err, m64_mis);
    else chk("idle64", m64_rd | 64'({m64_err, m64_mis}), 64'd0);
  end

  task automatic access(input string nm, input logic s, input logic [3:0] f,
                        input logic [31:0] a, input logic [63:0] wd,
                        input int gd, input logic [63:0] rd, input logic me,
                        input logic [31:0] eaddr, input logic [7:0] ebe,
                        input logic [63:0] ewd, input logic [63:0] erd,
                        input logic ee, input logic em);
    int t0;
    int nreq;
    logic fast;
    logic st;
    fast = ee && !me;
    st = f inside {4'd5, 4'd6, 4'd7, 4'd9};
    @(posedge clk); #1;
    dsel = s;
    chk({nm, ".ready"}, 64'(obs_ready), 64'd1);
    t0 = cyc;
    sbq.push_back('{erd, ee, em, t0 + (fast ? 1 : 3 + gd)});
    v = 1'b1; func = f; addr = a; wdata = wd;
    @(posedge clk); #1;
    v = 1'b0;
    if (fast) begin
      @(negedge clk);
      chk({nm, ".no_req"}, 64'(obs_req), 64'd0);
    end else begin
      nreq = 0;
      for (int i = 0; i <= gd; i++) begin
        @(negedge clk);
        if (obs_req) nreq++;
        if (i == gd) begin
          chk({nm, ".addr"}, 64'(obs_addr), 64'(eaddr));
          chk({nm, ".be"}, 64'(obs_be), 64'(ebe));
          chk({nm, ".wdata"}, obs_wd, ewd);
          chk({nm, ".we"}, 64'(obs_we), 64'(st));
          gnt = 1'b1;
        end
      end
      chk({nm, ".req_cycles"}, 64'(nreq), 64'(gd + 1));
      @(posedge clk); #1;
      gnt = 1'b0; rvalid = 1'b1; rdata = rd; merr = me;
      @(negedge clk);
      chk({nm, ".req_dropped"}, 64'(obs_req), 64'd0);
      @(posedge clk); #1;
      rvalid = 1'b0; merr = 1'b0; rdata = 64'h0;
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic tmo_test();
    int t0;
    int nreq;
    @(posedge clk); #1;
    dsel = 1'b0;
    t0 = cyc;
    sbq.push_back('{64'h0, 1'b1, 1'b0, t0 + 9});
    v = 1'b1; func = 4'd0; addr = 32'h40;
    @(posedge clk); #1;
    v = 1'b0;
    nreq = 0;
    repeat (12) begin
      @(negedge clk);
      if (obs_req) nreq++;
    end
    chk("tmo.req_cycles", 64'(nreq), 64'd8);
    chk("tmo.req_after", 64'(obs_req), 64'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; v = 1'b0; gnt = 1'b0; rvalid = 1'b0; merr = 1'b0;
    dsel = 1'b0; func = 4'd0; addr = 32'h0; wdata = 64'h0; rdata = 64'h0;
    repeat (3) @(negedge clk);
    chk("rst32.ctl", 64'({m32_ready, m32_rv, m32_err, m32_mis, m32_req,
                          m32_we}), 64'b100000);
    chk("rst32.bus", 64'({m32_addr, m32_be}) | 64'(m32_wd), 64'd0);
    chk("rst64.ctl", 64'({m64_ready, m64_rv, m64_err, m64_mis, m64_req,
                          m64_we}), 64'b100000);
    chk("rst64.bus", 64'({m64_addr, m64_be}) | m64_wd, 64'd0);
    rst = 1'b0;

    // name s f addr wdata gd rdata merr eaddr ebe ewd erd err mis
    access("lb", 0, 4'd2, 32'h103, 0, 0, 64'h80FF_1234, 0,
           32'h100, 8'h08, 0, 64'hFFFF_FF80, 0, 0);
    access("sh", 0, 4'd6, 32'h202, 64'hABCD, 4, 64'hDEAD_BEEF, 0,
           32'h200, 8'h0C, 64'hABCD_0000, 0, 0, 0);
    access("lw_mis", 0, 4'd0, 32'h101, 0, 0, 0, 0,
           0, 0, 0, 0, 1, 1);
    access("lhu", 0, 4'd3, 32'h102, 0, 0, 64'h8001_0000, 0,
           32'h100, 8'h0C, 0, 64'h0000_8001, 0, 0);
    access("lh", 0, 4'd1, 32'h102, 0, 1, 64'h8001_0000, 0,
           32'h100, 8'h0C, 0, 64'hFFFF_8001, 0, 0);
    access("lbu", 0, 4'd4, 32'h101, 0, 0, 64'h0000_A500, 0,
           32'h100, 8'h02, 0, 64'h0000_00A5, 0, 0);
    access("sb", 0, 4'd7, 32'h101, 64'h1234_5678, 0, 0, 0,
           32'h100, 8'h02, 64'h3456_7800, 0, 0, 0);
    access("ld32", 0, 4'd8, 32'h100, 0, 0, 0, 0,
           0, 0, 0, 0, 1, 0);
    access("ill12", 0, 4'd12, 32'h100, 0, 0, 0, 0,
           0, 0, 0, 0, 1, 0);
    access("buserr", 0, 4'd0, 32'h200, 0, 2, 64'h1234, 1,
           32'h200, 8'h0F, 0, 0, 1, 0);

    // reset while in REQ drops mem_req asynchronously
    @(posedge clk); #1;
    dsel = 1'b0; v = 1'b1; func = 4'd0; addr = 32'h40;
    @(posedge clk); #1;
    v = 1'b0;
    @(negedge clk);
    chk("rstreq.req_before", 64'(obs_req), 64'd1);
    #2 rst = 1'b1;
    #1 chk("rstreq.req_async", 64'(obs_req), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstreq.ready", 64'(obs_ready), 64'd1);

    // reset while in WAIT, then a stale response
    @(posedge clk); #1;
    v = 1'b1; func = 4'd0; addr = 32'h44;
    @(posedge clk); #1;
    v = 1'b0;
    @(negedge clk);
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rvalid = 1'b1; rdata = 64'h5555_AAAA;
    @(negedge clk);
    rvalid = 1'b0; rdata = 64'h0;
    repeat (3) @(negedge clk);
    chk("rstwait.ready", 64'(obs_ready), 64'd1);
    access("sw", 0, 4'd5, 32'h300, 64'hCAFE_F00D, 0, 0, 0,
           32'h300, 8'h0F, 64'hCAFE_F00D, 0, 0, 0);

    access("lwu64", 1, 4'd10, 32'h14, 0, 0, 64'hF000_0000_0000_0000, 0,
           32'h10, 8'hF0, 0, 64'h0000_0000_F000_0000, 0, 0);
    access("ld64", 1, 4'd8, 32'h18, 0, 1, 64'h8000_0000_0000_0001, 0,
           32'h18, 8'hFF, 0, 64'h8000_0000_0000_0001, 0, 0);
    access("sd64", 1, 4'd9, 32'h20, 64'h1122_3344_5566_7788, 0, 0, 0,
           32'h20, 8'hFF, 64'h1122_3344_5566_7788, 0, 0, 0);
    access("lw64", 1, 4'd0, 32'h4, 0, 0, 64'h8000_0001_0000_0000, 0,
           32'h0, 8'hF0, 0, 64'hFFFF_FFFF_8000_0001, 0, 0);
    access("lb64", 1, 4'd2, 32'h7, 0, 0, 64'h7F00_0000_0000_0000, 0,
           32'h0, 8'h80, 0, 64'h7F, 0, 0);
    access("lh64_mis", 1, 4'd1, 32'h3, 0, 0, 0, 0,
           0, 0, 0, 0, 1, 1);
    access("ld64_mis", 1, 4'd8, 32'h14, 0, 0, 0, 0,
           0, 0, 0, 0, 1, 1);

`ifdef LSU_TIMEOUT_EN
    tmo_test();
`endif

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    chk("sb.drained", 64'(sbq.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
